// File: rtl/mib_pkg.sv
// Shared definitions for the move-instruction-buffer handshake endpoints.
package mib_pkg;

  localparam int MIB_DEFAULT_WIDTH = 32;

  typedef struct packed {
    logic valid;
    logic ack;
  } mib_hs_t;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mib_ring_store.sv
// Circular word store with free-running write/read pointers; the caller owns flow control.
module mib_ring_store
  import mib_pkg::*;
#(
  parameter int WIDTH = MIB_DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage contents survive reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/mib_dest_endpoint.sv
// MIB destination responder: reserves slots on dest_valid, fills them in order, feeds the unit.
// Optional protocol checker and proto_err output enabled by MIB_DEST_PROTOCOL_CHECK_EN.
module mib_dest_endpoint
  import mib_pkg::*;
#(
  parameter int WIDTH = MIB_DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dest_valid,
  output logic             dest_ack,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data,
  output logic             data_ready,
  output logic             unit_valid,
  output logic [WIDTH-1:0] unit_data,
  input  logic             unit_ack
`ifdef MIB_DEST_PROTOCOL_CHECK_EN
  ,
  output logic             proto_err
`endif
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [CW-1:0] reserved_q, reserved_d;
  logic [CW-1:0] filled_q, filled_d;
  logic          ack_q, ack_d;
  logic [CW:0]   occ_d;
  mib_hs_t       dest_hs;
  logic          res, fill, pop;

  assign dest_hs    = '{valid: dest_valid, ack: ack_q};
  assign dest_ack   = ack_q;
  assign data_ready = (reserved_q != '0);
  assign unit_valid = (filled_q != '0);

  assign res  = dest_hs.valid & dest_hs.ack;
  assign fill = data_valid & data_ready;
  assign pop  = unit_ack & unit_valid;

  // Net deltas let reserve, fill and pop all land in the same cycle.
  always_comb begin
    reserved_d = reserved_q + CW'(res) - CW'(fill);
    filled_d   = filled_q + CW'(fill) - CW'(pop);
    occ_d      = {1'b0, reserved_d} + {1'b0, filled_d};
    ack_d      = (occ_d < DEPTH_C);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reserved_q <= '0;
      filled_q   <= '0;
      ack_q      <= 1'b0;
    end else begin
      reserved_q <= reserved_d;
      filled_q   <= filled_d;
      ack_q      <= ack_d;
    end
  end

  mib_ring_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (fill),
    .wr_data (data),
    .rd_en   (pop),
    .rd_data (unit_data)
  );

`ifdef MIB_DEST_PROTOCOL_CHECK_EN
  logic proto_err_q, proto_err_d;

  always_comb begin
    proto_err_d = proto_err_q | (data_valid & ~data_ready) | (unit_ack & ~unit_valid);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) proto_err_q <= 1'b0;
    else       proto_err_q <= proto_err_d;
  end

  assign proto_err = proto_err_q;

`ifdef FORMAL
  logic [CW:0] occ_q;
  assign occ_q = {1'b0, reserved_q} + {1'b0, filled_q};

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (occ_q <= DEPTH_C);
      assert (!ack_q || (occ_q < DEPTH_C));
    end
  end
`endif
`endif

endmodule

// File: tb/tb_mib_dest_endpoint.sv
// Self-checking bench for mib_dest_endpoint (DEPTH=4, WIDTH=8): queue model plus directed checks.
module tb_mib_dest_endpoint;

  localparam int W = 8;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         dest_valid, data_valid, unit_ack;
  logic [W-1:0] data;
  logic         dest_ack, data_ready, unit_valid;
  logic [W-1:0] unit_data;
`ifdef MIB_DEST_PROTOCOL_CHECK_EN
  logic         proto_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mib_dest_endpoint #(.WIDTH(W), .DEPTH(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .dest_valid (dest_valid),
    .dest_ack   (dest_ack),
    .data_valid (data_valid),
    .data       (data),
    .data_ready (data_ready),
    .unit_valid (unit_valid),
    .unit_data  (unit_data),
    .unit_ack   (unit_ack)
`ifdef MIB_DEST_PROTOCOL_CHECK_EN
    ,
    .proto_err  (proto_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: open reservations are a count, buffered words a FIFO queue.
  int           m_res = 0;
  logic [W-1:0] m_words[$];
  bit           m_ack = 0;
  bit           m_perr = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_res = 0;
      m_words.delete();
      m_ack = 0;
      m_perr = 0;
    end else begin
      bit r, f, p;
      r = dest_valid && m_ack;
      f = data_valid && (m_res > 0);
      p = unit_ack && (m_words.size() > 0);
      if ((data_valid && m_res == 0) || (unit_ack && m_words.size() == 0)) m_perr = 1;
      if (p) void'(m_words.pop_front());
      if (f) m_words.push_back(data);
      m_res = m_res + int'(r) - int'(f);
      m_ack = (m_res + m_words.size()) < D;
    end
  end

  always @(negedge clock) begin
    chk("m_dest_ack", {31'b0, dest_ack}, {31'b0, m_ack});
    chk("m_data_ready", {31'b0, data_ready}, {31'b0, (m_res != 0)});
    chk("m_unit_valid", {31'b0, unit_valid}, {31'b0, (m_words.size() != 0)});
    if (m_words.size() != 0) chk("m_unit_data", {24'b0, unit_data}, {24'b0, m_words[0]});
`ifdef MIB_DEST_PROTOCOL_CHECK_EN
    chk("m_proto_err", {31'b0, proto_err}, {31'b0, m_perr});
`endif
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  initial begin
    reset = 1'b1;
    dest_valid = 0; data_valid = 0; unit_ack = 0; data = '0;
    tick; tick;
    reset = 1'b0; dest_valid = 1;
    chk1("first_cycle_ack", dest_ack, 1'b0);
    tick;
    chk1("ack_after_release", dest_ack, 1'b1);
    tick; tick; tick; tick;
    chk1("ack_low_at_4_res", dest_ack, 1'b0);
    chk1("ready_with_res", data_ready, 1'b1);
    tick;
    chk1("ack_stays_low", dest_ack, 1'b0);
    dest_valid = 0;

    reset = 1'b1; #1;
    chk1("rst_ack", dest_ack, 1'b0);
    chk1("rst_ready", data_ready, 1'b0);
    tick; reset = 1'b0;
    tick;
    dest_valid = 1; tick; dest_valid = 0;
    chk1("ready_before_fill", data_ready, 1'b1);
    data_valid = 1; data = 8'hA5; tick; data_valid = 0;
    chk1("uv_after_fill", unit_valid, 1'b1);
    chk("ud_a5", {24'b0, unit_data}, 32'hA5);
    unit_ack = 1; tick; unit_ack = 0;
    chk1("uv_after_pop", unit_valid, 1'b0);

    dest_valid = 1; tick; tick; tick; dest_valid = 0;
    data_valid = 1; unit_ack = 1;
    data = 8'h11; tick; chk("stream_11", {24'b0, unit_data}, 32'h11);
    data = 8'h22; tick; chk("stream_22", {24'b0, unit_data}, 32'h22);
    data = 8'h33; tick; data_valid = 0; chk("stream_33", {24'b0, unit_data}, 32'h33);
    tick; unit_ack = 0;
    chk1("stream_drained", unit_valid, 1'b0);

    dest_valid = 1; tick; tick; tick; tick; dest_valid = 0;
    data_valid = 1;
    for (int i = 0; i < 4; i++) begin
      data = 8'h40 + 8'(i);
      tick;
    end
    data_valid = 0;
    chk1("full_ack_low", dest_ack, 1'b0);
    unit_ack = 1; dest_valid = 1; tick; unit_ack = 0;
    chk1("pop_raises_ack", dest_ack, 1'b1);
    chk1("no_res_in_pop_cycle", data_ready, 1'b0);
    chk("head_after_pop", {24'b0, unit_data}, 32'h41);
    tick; dest_valid = 0;
    chk1("res_completes", data_ready, 1'b1);
    chk1("ack_low_again", dest_ack, 1'b0);

    unit_ack = 1; tick; tick; unit_ack = 0;
    dest_valid = 1; data_valid = 1; data = 8'h55; unit_ack = 1;
    tick; dest_valid = 0; data_valid = 0; unit_ack = 0;
    chk1("rfp_ready", data_ready, 1'b1);
    chk("rfp_head", {24'b0, unit_data}, 32'h55);
    data_valid = 1; data = 8'h66; unit_ack = 1; tick; data_valid = 0;
    chk("fp_head", {24'b0, unit_data}, 32'h66);
    tick; unit_ack = 0;
    chk1("all_empty", unit_valid, 1'b0);
    chk1("no_res_left", data_ready, 1'b0);

    data_valid = 1; data = 8'h7E; tick; data_valid = 0;
    chk1("ignored_word", unit_valid, 1'b0);
`ifdef MIB_DEST_PROTOCOL_CHECK_EN
    chk1("perr_set", proto_err, 1'b1);
    tick; tick;
    chk1("perr_sticky", proto_err, 1'b1);
`endif

    dest_valid = 1; tick; tick; dest_valid = 0;
    data_valid = 1; data = 8'h99; tick; data_valid = 0;
    reset = 1'b1; #1;
    chk1("mid_rst_ack", dest_ack, 1'b0);
    chk1("mid_rst_ready", data_ready, 1'b0);
    chk1("mid_rst_uv", unit_valid, 1'b0);
`ifdef MIB_DEST_PROTOCOL_CHECK_EN
    chk1("mid_rst_perr", proto_err, 1'b0);
`endif
    tick; reset = 1'b0; tick; tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
